// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared MIPS definitions for the PC sequencer: FSM state encoding, the
// opcode/funct constants decoded by the next-PC logic, and a helper that
// builds the word-aligned branch displacement.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    COMMIT = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FUNCT_JR = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // Sign-extended 16-bit immediate shifted left by two (word offset -> bytes).
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Instruction-memory fetch handshake.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch address, equal to the current PC
//   imem_ack   : fetch complete; imem_rdata is valid in the same cycle
//   imem_rdata : fetched instruction word
// master = sequencer side, slave = memory side.
interface pc_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// next_pc_calc
// Purely combinational next-PC selection for one instruction.
//   instr    : instruction word being executed
//   pc       : PC of that instruction
//   rs_data  : value of register instr[25:21]
//   rt_data  : value of register instr[20:16]
//   next_pc  : address of the following instruction
//   is_jal   : instruction is jal (needs a $31 link write)
//   misalign : jr target had non-zero low bits (they are dropped in next_pc)
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] next_pc,
  output logic        is_jal,
  output logic        misalign
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // pc4 wraps naturally modulo 2^32, so 32'hFFFF_FFFC steps to 0.
  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign pc4           = pc + 32'd4;
  assign branch_target = pc4 + branch_offset(instr[15:0]);
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};

  // Default is the sequential path; only control-flow opcodes override it.
  always_comb begin
    next_pc  = pc4;
    is_jal   = 1'b0;
    misalign = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          next_pc  = {rs_data[31:2], 2'b00};
          misalign = |rs_data[1:0];
        end
      end
      OP_J: begin
        next_pc = jump_target;
      end
      OP_JAL: begin
        next_pc = jump_target;
        is_jal  = 1'b1;
      end
      OP_BEQ: begin
        if (rs_data == rt_data) next_pc = branch_target;
      end
      OP_BNE: begin
        if (rs_data != rt_data) next_pc = branch_target;
      end
      default: begin
        next_pc = pc4;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Five-state instruction sequencer: fetches a word, reads its source
// registers, resolves the next PC and commits it once the datapath is free.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem                : fetch handshake (master modport)
//   rs_addr / rt_addr   : register-file read addresses (instr[25:21]/[20:16])
//   rs_data / rt_data   : combinational register-file read data
//   stall               : datapath busy, holds the commit
//   instr / instr_valid : current instruction and its one-cycle issue pulse
//   pc                  : current PC
//   link_we / link_data : $31 write for jal
//   addr_err            : one-cycle pulse on a misaligned jr target
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_sequencer_if.master        imem,
  output logic [4:0]            rs_addr,
  output logic [4:0]            rt_addr,
  input  logic [31:0]           rs_data,
  input  logic [31:0]           rt_data,
  input  logic                  stall,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [31:0]           pc,
  output logic                  link_we,
  output logic [31:0]           link_data,
  output logic                  addr_err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] link_data_q, link_data_d;
  logic        instr_valid_q, instr_valid_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] calc_rs;
  logic [31:0] calc_rt;
  logic [31:0] calc_next_pc;
  logic        calc_is_jal;
  logic        calc_misalign;

  // In DECODE the live register data feeds the calculator so that addr_err
  // and instr_valid can be registered into EXEC without an extra cycle; from
  // EXEC on the captured copies are used, which hold the same values.
  assign calc_rs = (state_q == DECODE) ? rs_data : rs_q;
  assign calc_rt = (state_q == DECODE) ? rt_data : rt_q;

  next_pc_calc u_next_pc_calc (
    .instr    (instr_q),
    .pc       (pc_q),
    .rs_data  (calc_rs),
    .rt_data  (calc_rt),
    .next_pc  (calc_next_pc),
    .is_jal   (calc_is_jal),
    .misalign (calc_misalign)
  );

  assign rs_addr        = instr_q[25:21];
  assign rt_addr        = instr_q[20:16];
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign link_data      = link_data_q;
  assign addr_err       = addr_err_q;
  // The link write happens in the same cycle the PC commits, so it follows
  // stall directly; reset drops it at once because the state leaves COMMIT.
  assign link_we        = (state_q == COMMIT) && !stall && calc_is_jal;

  // Next-state and next-value logic for every register. Acks outside FETCH
  // and stalls outside COMMIT simply fall through to the hold defaults.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    next_pc_d     = next_pc_q;
    link_data_d   = link_data_q;
    instr_valid_d = 1'b0;
    addr_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        rs_d          = rs_data;
        rt_d          = rt_data;
        instr_valid_d = 1'b1;
        addr_err_d    = calc_misalign;
        state_d       = EXEC;
      end
      EXEC: begin
        next_pc_d   = calc_next_pc;
        link_data_d = pc_q + 32'd4;
        state_d     = COMMIT;
      end
      COMMIT: begin
        if (!stall) begin
          pc_d    = next_pc_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All sequencer state; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      rs_q          <= 32'h0;
      rt_q          <= 32'h0;
      next_pc_q     <= RESET_PC;
      link_data_q   <= 32'h0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      next_pc_q     <= next_pc_d;
      link_data_q   <= link_data_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Scoreboard bench for pc_sequencer: each fetched word pushes its expected
// issue/commit result; the entry is popped when the DUT issues the word.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        is_jal;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        link_we;
  logic [31:0] link_data;
  logic        addr_err;

  logic [31:0] regs [32];
  exp_t        sb [$];
  int          n_checks;
  int          n_fail;
  int          cyc;
  int          last_valid_cyc;
  logic [31:0] model_pc;
  bit          hold_ack;

  pc_sequencer_if imem_if ();

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_if),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .link_we     (link_we),
    .link_data   (link_data),
    .addr_err    (addr_err)
  );

  // Free-running clock and cycle counter used for issue-spacing checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational register file model.
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  // Reference next-PC model for one instruction.
  function automatic exp_t model(input logic [31:0] p, input logic [31:0] ins,
                                 input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [31:0] p4;
    logic [31:0] off;
    p4       = p + 32'd4;
    off      = {{14{ins[15]}}, ins[15:0], 2'b00};
    e.pc     = p;
    e.instr  = ins;
    e.link   = p4;
    e.next_pc = p4;
    e.is_jal = 1'b0;
    e.err    = 1'b0;
    if (ins[31:26] == 6'd0 && ins[5:0] == 6'h08) begin
      e.next_pc = rs & 32'hFFFF_FFFC;
      e.err     = (rs[1:0] != 2'b00);
    end else if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3) begin
      e.next_pc = {p4[31:28], ins[25:0], 2'b00};
      e.is_jal  = (ins[31:26] == 6'd3);
    end else if (ins[31:26] == 6'd4) begin
      if (rs == rt) e.next_pc = p4 + off;
    end else if (ins[31:26] == 6'd5) begin
      if (rs != rt) e.next_pc = p4 + off;
    end
    return e;
  endfunction

  // Runs one instruction through FETCH..COMMIT, starting from a negedge,
  // and returns at the negedge of the following FETCH.
  task automatic run_instr(input logic [31:0] ins, input int ack_delay,
                           input int commit_stall, input bit fetch_stall);
    exp_t        e;
    exp_t        got;
    int          n;
    logic [31:0] addr0;
    n = 0;
    while (!imem_if.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (imem_if.imem_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fetch_req_timeout: imem_req=%b required 1", imem_if.imem_req);
      return;
    end
    n_checks++;
    if (imem_if.imem_addr !== model_pc) begin
      n_fail++;
      $display("[TB] FAIL fetch_addr: got %h required %h", imem_if.imem_addr, model_pc);
    end
    addr0 = imem_if.imem_addr;
    for (int d = 0; d < ack_delay; d++) begin
      imem_if.imem_ack = 1'b0;
      stall = fetch_stall && (d == 0);
      @(negedge clk);
      n_checks++;
      if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== addr0) begin
        n_fail++;
        $display("[TB] FAIL fetch_hold: req=%b addr=%h required 1 %h",
                 imem_if.imem_req, imem_if.imem_addr, addr0);
      end
    end
    stall = 1'b0;
    sb.push_back(model(model_pc, ins, regs[ins[25:21]], regs[ins[20:16]]));
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = ins;
    @(negedge clk);
    if (hold_ack) imem_if.imem_rdata = 32'hDEAD_BEEF;
    else          imem_if.imem_ack   = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 4);
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL issue_timeout: instr_valid=%b required 1", instr_valid);
      void'(sb.pop_front());
      return;
    end
    last_valid_cyc = cyc;
    e = sb.pop_front();
    got.instr = instr;
    n_checks++;
    if (got.instr !== e.instr || pc !== e.pc || addr_err !== e.err) begin
      n_fail++;
      $display("[TB] FAIL issue: instr=%h pc=%h addr_err=%b required %h %h %b",
               instr, pc, addr_err, e.instr, e.pc, e.err);
    end
    stall = (commit_stall > 0);
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pulse_width: instr_valid=%b addr_err=%b required 0 0",
               instr_valid, addr_err);
    end
    for (int s = 0; s < commit_stall; s++) begin
      n_checks++;
      if (pc !== e.pc || imem_if.imem_req !== 1'b0 || link_we !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL commit_stall: pc=%h req=%b link_we=%b required %h 0 0",
                 pc, imem_if.imem_req, link_we, e.pc);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    n_checks++;
    if (link_we !== e.is_jal || (e.is_jal && link_data !== e.link)) begin
      n_fail++;
      $display("[TB] FAIL link: link_we=%b link_data=%h required %b %h",
               link_we, link_data, e.is_jal, e.link);
    end
    @(negedge clk);
    n_checks++;
    if (pc !== e.next_pc || link_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL commit_pc: pc=%h link_we=%b required %h 0", pc, link_we, e.next_pc);
    end
    model_pc = e.next_pc;
  endtask

  // Reset values, then the first request one cycle after release.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pc !== RESET_PC || instr !== 32'h0 || imem_if.imem_req !== 1'b0 ||
        instr_valid !== 1'b0 || link_we !== 1'b0 || addr_err !== 1'b0 ||
        link_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: pc=%h instr=%h req=%b iv=%b lwe=%b aerr=%b ld=%h required all zero",
               pc, instr, imem_if.imem_req, instr_valid, link_we, addr_err, link_data);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_if.imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL req_after_release: got %b required 0", imem_if.imem_req);
    end
    @(negedge clk);
    n_checks++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("[TB] FAIL first_req: req=%b addr=%h required 1 %h",
               imem_if.imem_req, imem_if.imem_addr, RESET_PC);
    end
    model_pc = RESET_PC;
  endtask

  // Back-to-back sequential words with ack held high throughout.
  task automatic test_sequential();
    int c0;
    int c1;
    hold_ack = 1'b1;
    run_instr(32'h0000_0000, 0, 0, 1'b0);
    c0 = last_valid_cyc;
    run_instr(32'h2001_0005, 0, 0, 1'b0);
    c1 = last_valid_cyc;
    n_checks++;
    if (c1 - c0 !== 4) begin
      n_fail++;
      $display("[TB] FAIL issue_period_1: got %0d required 4", c1 - c0);
    end
    run_instr(32'h0000_0020, 0, 0, 1'b0);
    n_checks++;
    if (last_valid_cyc - c1 !== 4) begin
      n_fail++;
      $display("[TB] FAIL issue_period_2: got %0d required 4", last_valid_cyc - c1);
    end
    hold_ack = 1'b0;
    imem_if.imem_ack = 1'b0;
    n_checks++;
    if (pc !== 32'h0000_000C) begin
      n_fail++;
      $display("[TB] FAIL seq_pc: got %h required 0000000c", pc);
    end
  endtask

  // j into 0x20, then beq/bne taken and not taken.
  task automatic test_branches();
    run_instr(32'h0800_0008, 0, 0, 1'b0);
    run_instr(32'h1022_FFFF, 0, 0, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0020) begin
      n_fail++;
      $display("[TB] FAIL beq_taken: got %h required 00000020", pc);
    end
    run_instr(32'h1023_FFFF, 0, 0, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0024) begin
      n_fail++;
      $display("[TB] FAIL beq_not_taken: got %h required 00000024", pc);
    end
    run_instr(32'h1423_0004, 0, 0, 1'b0);
    run_instr(32'h1422_0004, 0, 0, 1'b0);
  endtask

  // jal at 0x100 with a 5-cycle stall in COMMIT.
  task automatic test_jal_stall();
    run_instr(32'h0800_0040, 0, 0, 1'b0);
    run_instr(32'h0C00_0010, 0, 5, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0040) begin
      n_fail++;
      $display("[TB] FAIL jal_target: got %h required 00000040", pc);
    end
  endtask

  // jr aligned and misaligned, then jr to the top word and a wrap to 0.
  task automatic test_jr_wrap();
    regs[31] = 32'h0000_0040;
    run_instr(32'h03E0_0008, 0, 0, 1'b0);
    regs[31] = 32'h0000_0042;
    run_instr(32'h03E0_0008, 0, 0, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0040) begin
      n_fail++;
      $display("[TB] FAIL jr_misaligned_pc: got %h required 00000040", pc);
    end
    regs[31] = 32'hFFFF_FFFC;
    run_instr(32'h03E0_0008, 0, 0, 1'b0);
    run_instr(32'h0000_0000, 0, 0, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0000) begin
      n_fail++;
      $display("[TB] FAIL pc_wrap: got %h required 00000000", pc);
    end
  endtask

  // Ack delayed three cycles with a stall pulse during FETCH.
  task automatic test_fetch_delay();
    run_instr(32'h0000_0000, 3, 0, 1'b1);
  endtask

  // Reset in the middle of a stalled jal commit.
  task automatic test_reset_mid_commit();
    int n;
    n = 0;
    while (!imem_if.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = 32'h0C00_0010;
    @(negedge clk);
    imem_if.imem_ack = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    stall = 1'b0;
    #1;
    n_checks++;
    if (link_we !== 1'b0 || pc !== RESET_PC || imem_if.imem_req !== 1'b0 ||
        instr !== 32'h0 || link_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_commit: lwe=%b pc=%h req=%b instr=%h ld=%h required 0 %h 0 0 0",
               link_we, pc, imem_if.imem_req, instr, link_data, RESET_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("[TB] FAIL req_after_abandon: req=%b addr=%h required 1 %h",
               imem_if.imem_req, imem_if.imem_addr, RESET_PC);
    end
    model_pc = RESET_PC;
  endtask

  // Test sequence and summary.
  initial begin
    n_checks           = 0;
    n_fail             = 0;
    cyc                = 0;
    last_valid_cyc     = 0;
    hold_ack           = 1'b0;
    model_pc           = RESET_PC;
    rst_n              = 1'b0;
    stall              = 1'b0;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 32'h0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'd5;
    regs[2] = 32'd5;
    regs[3] = 32'd7;
    test_reset();
    test_sequential();
    test_branches();
    test_jal_stall();
    test_jr_wrap();
    test_fetch_delay();
    test_reset_mid_commit();
    run_instr(32'h0000_0000, 0, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-002 The module SHALL have a single clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address; equals pc.
REQ-007 imem_ack  input  1  fetch complete; imem_rdata valid in this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 rs_addr / rt_addr  output  5 each  register-file read addresses, instr[25:21] and instr[20:16].
REQ-010 rs_data / rt_data  input  32 each  combinational register-file read data.
REQ-011 stall  input  1  datapath busy; holds the PC commit.
REQ-012 instr  output  32  latched current instruction.
REQ-013 instr_valid  output  1  one-cycle pulse when instr is issued to the datapath.
REQ-014 pc  output  32  current PC.
REQ-015 link_we / link_data  output  1 / 32  $31 write request and value for jal.
REQ-016 addr_err  output  1  one-cycle pulse on a misaligned jr target.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, FETCH, DECODE, EXEC, COMMIT.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next clock edge.
REQ-019 FETCH SHALL drive imem_req=1 combinationally, and SHALL latch imem_rdata into instr and go to DECODE on imem_ack=1; otherwise it SHALL hold.
REQ-020 DECODE SHALL last one cycle; rs_data and rt_data SHALL be registered at its end.
REQ-021 EXEC SHALL assert instr_valid for exactly one cycle, compute next_pc, register it, and go to COMMIT.
REQ-022 COMMIT SHALL hold while stall=1; on stall=0 it SHALL load pc<=next_pc, pulse link_we if the instruction is jal, and go to FETCH.
REQ-023 Decode: jr is op=6'b000000 with funct=6'b001000; all other R-type instructions are sequential.
REQ-024 next_pc SHALL be selected as follows:
  - jr: rs_data with bits[1:0] forced to 0; addr_err pulses in EXEC if rs_data[1:0]!=0.
  - j (000010) / jal (000011): {pc4[31:28], instr[25:0], 2'b00}.
  - beq (000100): pc4+(sext(instr[15:0])<<2) if rs_data==rt_data, else pc4.
  - bne (000101): the same target, taken if rs_data!=rt_data.
  - All other instructions: pc4.
REQ-025 pc4 SHALL be pc+4, computed modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-026 link_data SHALL equal pc4 of the jal instruction, and SHALL be valid while link_we=1.
REQ-027 imem_ack outside FETCH SHALL be ignored.
REQ-028 A stall asserted in any state other than COMMIT SHALL have no effect.
REQ-029 One instruction SHALL complete every 4 cycles minimum: FETCH with ack in the same cycle, then DECODE, EXEC, COMMIT.

Reset
REQ-030 On rst_n=0 the module SHALL immediately force state=IDLE, pc=RESET_PC, instr=0, next_pc=RESET_PC, and imem_req, instr_valid, link_we, addr_err, link_data=0.
REQ-031 A reset mid-fetch or mid-stall SHALL abandon the instruction with no link write and no PC update; the first request after release SHALL use RESET_PC.

Structure
REQ-032 Opcode and funct constants (OP_RTYPE, FUNCT_JR, OP_J, OP_JAL, OP_BEQ, OP_BNE) and the state encodings SHALL live in the shared MIPS definitions package/include.
REQ-033 next-PC selection SHALL be one combinational sub-module, next_pc_calc, with inputs instr, pc, rs_data, rt_data and outputs next_pc, is_jal, misalign.

Verification
REQ-034 Reset release with ack held high -> imem_req rises 1 cycle later at addr 0; instr_valid pulses every 4 cycles; pc steps 0, 4, 8.
REQ-035 instr=0x03E00008 (jr $31) with rs_data=0x0000_0040 -> pc=0x40 after COMMIT, addr_err=0; with rs_data=0x0000_0042 -> pc=0x40, addr_err pulses once.
REQ-036 jal 0x0C000010 at pc=0x100 -> link_we=1 with link_data=0x104 in COMMIT, then pc=0x40.
REQ-037 beq with rs==rt, imm=0xFFFF, at pc=0x20 -> pc=0x20; the same with rs!=rt -> pc=0x24.
REQ-038 stall=1 for 5 cycles in COMMIT -> pc unchanged and no new imem_req until stall drops; a stall pulse in FETCH is ignored.
REQ-039 rst_n=0 asserted mid-COMMIT of a jal -> no link_we and pc=RESET_PC; an ack delayed 3 cycles holds FETCH with imem_addr stable.
